// File: rtl/mem_ctrl.sv
// Word-addressed memory controller: internal RAM plus a TX FIFO window.
// Requests complete with a one-cycle cpu_ready pulse after 2+ cycles.
module mem_ctrl #(
  parameter int          ADDR_BITS  = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        bus_err,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RAM_WORDS = 32'(1) << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_FIFO,
    RESPOND
  } state_t;

  state_t state, state_nx;

  logic        cap_rw;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] ram  [2**ADDR_BITS];
  logic [31:0] fifo [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic fifo_full, fifo_empty;
  logic push, pop, ram_we, rd_load;
  logic is_ram, is_tx, is_st, is_bad;
  logic [31:0] status_word, rd_result;

  always_comb begin
    is_ram = cap_addr < RAM_WORDS;
    is_tx  = cap_addr == IO_BASE;
    is_st  = cap_addr == IO_BASE + 32'd1;
    is_bad = !(is_ram || is_tx || is_st);
  end

  assign fifo_full   = count == CW'(FIFO_DEPTH);
  assign fifo_empty  = count == '0;
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_empty ? '0 : fifo[rd_ptr];
  assign pop         = out_valid && out_ready;
  assign status_word = {27'b0, 3'(count), fifo_full, fifo_empty};

  always_comb begin
    rd_result = '0;
    unique case (1'b1)
      is_ram:  rd_result = ram[cap_addr[ADDR_BITS-1:0]];
      is_st:   rd_result = status_word;
      default: rd_result = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (cpu_req) state_nx = ACCESS;
      ACCESS:
        if (cap_rw && is_tx && fifo_full)
          state_nx = WAIT_FIFO;
        else
          state_nx = RESPOND;
      WAIT_FIFO: if (!fifo_full) state_nx = RESPOND;
      RESPOND:   state_nx = IDLE;
    endcase
  end

  // Reset gates every side effect so an abandoned access leaves no trace.
  always_comb begin
    push      = 1'b0;
    ram_we    = 1'b0;
    rd_load   = 1'b0;
    cpu_ready = 1'b0;
    bus_err   = 1'b0;
    unique case (state)
      IDLE: ;
      ACCESS: begin
        push    = cap_rw && is_tx && !fifo_full && !reset;
        ram_we  = cap_rw && is_ram && !reset;
        rd_load = !cap_rw;
      end
      WAIT_FIFO: push = !fifo_full && !reset;
      RESPOND: begin
        cpu_ready = 1'b1;
        bus_err   = is_bad;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_rw    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && cpu_req) begin
      cap_rw    <= cpu_rw;
      cap_addr  <= cpu_address;
      cap_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)        cpu_rdata <= '0;
    else if (rd_load) cpu_rdata <= rd_result;
  end

  always_ff @(posedge clock) begin
    if (ram_we) ram[cap_addr[ADDR_BITS-1:0]] <= cap_wdata;
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= cap_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl against a queue/array reference model.
// FIFO drain order is checked at every pop by the negedge monitor.
module tb_mem_ctrl;

  localparam logic [31:0] TX = 32'hFFFF_FFF0;
  localparam logic [31:0] ST = 32'hFFFF_FFF1;

  logic        clock, reset;
  logic        cpu_req, cpu_rw;
  logic [31:0] cpu_address, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, bus_err;
  logic [31:0] out_data;
  logic        out_valid, out_ready;

  mem_ctrl dut (
    .clock(clock),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_rw(cpu_rw),
    .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .bus_err(bus_err),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [1024];
  bit          known [1024];
  logic [31:0] q [$];
  int          ord_mode = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_of(int n);
    return 32'((n % 8) * 4 + (n == 4 ? 2 : 0) + (n == 0 ? 1 : 0));
  endfunction

  // Consumer: drives out_ready, then checks any pop against the queue head.
  always @(negedge clock) begin
    if (ord_mode == 2) out_ready = 1'($urandom);
    else               out_ready = (ord_mode == 1);
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) check("pop_empty", 32'd1, 32'd0);
      else begin
        check("pop_data", out_data, q[0]);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(bit rw, logic [31:0] a, logic [31:0] d);
    @(negedge clock);
    cpu_req = 1'b1;
    cpu_rw = rw;
    cpu_address = a;
    cpu_wdata = d;
    @(posedge clock);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_txn(bit rw, logic [31:0] a, logic [31:0] d);
    int lat, n;
    bit ram_hit, bad, chk_rd;
    logic [31:0] exp;
    logic [9:0] idx;
    idx = a[9:0];
    ram_hit = a < 32'd1024;
    bad = !(ram_hit || a == TX || a == ST);
    issue(rw, a, d);
    lat = 1;
    n = q.size();
    while (!cpu_ready && lat < 40) begin
      step();
      lat++;
    end
    if (!cpu_ready) check("resp_timeout", 32'd0, 32'd1);
    if (!(rw && a == TX)) check("latency", lat, 2);
    check("bus_err", 32'(bus_err), 32'(bad));
    exp = '0;
    chk_rd = 1'b0;
    if (rw) begin
      if (ram_hit) begin
        ram_m[idx] = d;
        known[idx] = 1'b1;
      end
      if (a == TX && cpu_ready) q.push_back(d);
    end else begin
      exp = ram_hit ? ram_m[idx] : (a == ST ? status_of(n) : 32'd0);
      chk_rd = !ram_hit || known[idx];
      if (chk_rd) check("rdata", cpu_rdata, exp);
    end
    step();
    check("ready_pulse", 32'(cpu_ready), 32'd0);
    if (chk_rd) check("rdata_hold", cpu_rdata, exp);
  endtask

  task automatic drain();
    int k;
    ord_mode = 1;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      step();
      k++;
    end
    step();
    check("drain_empty", 32'(out_valid), 32'd0);
    ord_mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int kind;
    reset = 1'b1;
    cpu_req = 1'b0;
    cpu_rw = 1'b0;
    cpu_address = '0;
    cpu_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_odata", out_data, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;

    do_txn(1'b1, 32'd5, 32'h1234_5678);
    do_txn(1'b0, 32'd5, 32'd0);

    do_txn(1'b1, 32'd0, 32'hA5A5_0000);
    do_txn(1'b0, 32'h0000_8000, 32'd0);
    do_txn(1'b1, 32'h0000_8000, 32'hDEAD_BEEF);
    do_txn(1'b0, 32'd0, 32'd0);

    for (int i = 1; i <= 4; i++) do_txn(1'b1, TX, 32'(i));
    do_txn(1'b0, ST, 32'd0);
    check("status_full", cpu_rdata, 32'h12);
    issue(1'b1, TX, 32'd5);
    for (int k = 1; k <= 4; k++) begin
      check("stall_noready", 32'(cpu_ready), 32'd0);
      step();
    end
    ord_mode = 1;
    step();
    ord_mode = 0;
    check("wait_push", 32'(cpu_ready), 32'd0);
    step();
    check("ready_after_pop", 32'(cpu_ready), 32'd1);
    check("stall_err", 32'(bus_err), 32'd0);
    if (cpu_ready) q.push_back(32'd5);
    step();
    check("stall_pulse", 32'(cpu_ready), 32'd0);
    drain();

    do_txn(1'b1, TX, 32'hA1);
    do_txn(1'b1, TX, 32'hB2);
    issue(1'b1, TX, 32'hC3);
    ord_mode = 1;
    step();
    ord_mode = 0;
    check("pushpop_ready", 32'(cpu_ready), 32'd1);
    if (cpu_ready) q.push_back(32'hC3);
    step();
    do_txn(1'b0, ST, 32'd0);
    check("pushpop_count", cpu_rdata, 32'h8);
    drain();

    do_txn(1'b1, TX, 32'h11);
    do_txn(1'b1, TX, 32'h22);
    issue(1'b1, TX, 32'h33);
    reset = 1'b1;
    step();
    check("rst_mid_ready", 32'(cpu_ready), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_odata", out_data, 32'd0);
    reset = 1'b0;
    q.delete();
    step();
    check("post_rst_ready", 32'(cpu_ready), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    do_txn(1'b0, 32'd5, 32'd0);

    @(negedge clock);
    cpu_req = 1'b1;
    cpu_rw = 1'b0;
    cpu_address = 32'd5;
    step();
    for (int j = 1; j <= 9; j++) begin
      check("b2b_ready", 32'(cpu_ready), 32'(j % 3 == 2));
      if (j % 3 == 2) check("b2b_rdata", cpu_rdata, ram_m[5]);
      if (j == 8) cpu_req = 1'b0;
      if (j < 9) step();
    end

    for (int i = 0; i < 16; i++) do_txn(1'b1, 32'(i), $urandom);
    do_txn(1'b1, 32'd1023, $urandom);
    do_txn(1'b0, 32'd1023, 32'd0);

    ord_mode = 2;
    repeat (150) begin
      kind = $urandom_range(0, 4);
      if (kind <= 1)
        a = ($urandom_range(0, 7) == 0) ? 32'd1023 : 32'($urandom_range(0, 15));
      else if (kind == 2) a = TX;
      else if (kind == 3) a = ST;
      else if ($urandom_range(0, 1) == 1)
        a = 32'h400 + 32'($urandom_range(0, 1000));
      else
        a = TX + 32'($urandom_range(2, 15));
      do_txn(1'($urandom), a, $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
